// File: rtl/isp_lite_axil_regs.sv
// AXI4-Lite register bank for the ISP-lite pipeline: shadow configuration committed
// at frame start, a frame counter and a frame-start interrupt.
module isp_lite_axil_regs #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] CFG0_RESET         = 32'h0000_0000
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  input  logic                            in_vsync,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg0_active,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg1_active,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg2_active,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg3_active,
  output logic                            irq
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t          w_state;
  r_state_t          r_state;
  logic              aw_held;
  logic              w_held;
  logic [2:0]        awaddr_q;
  logic [DW-1:0]     wdata_q;
  logic [SW-1:0]     wstrb_q;
  logic              write_fire;

  logic [3:0][DW-1:0] cfg_q;
  logic [3:0][DW-1:0] cfg_act;
  logic [1:0]         ctrl_q;
  logic [31:0]        frame_cnt_q;
  logic               irq_stat_q;
  logic               irq_en_q;
  logic               vsync_p1;
  logic               frame_start;
  logic [DW-1:0]      rd_word;
  logic               unused_bits;

  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_v;
    for (int b = 0; b < SW; b++)
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    return res;
  endfunction

  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign s00_axi_bresp = 2'b00;
  assign s00_axi_rresp = 2'b00;
  assign cfg0_active   = cfg_act[0];
  assign cfg1_active   = cfg_act[1];
  assign cfg2_active   = cfg_act[2];
  assign cfg3_active   = cfg_act[3];

  assign write_fire  = (w_state == W_IDLE) && aw_held && w_held;
  assign frame_start = in_vsync && !vsync_p1;

  // Write channel: AW and W are captured independently, the register is updated once both are held
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      w_state         <= W_IDLE;
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      aw_held         <= 1'b0;
      w_held          <= 1'b0;
      awaddr_q        <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (write_fire) begin
            aw_held         <= 1'b0;
            w_held          <= 1'b0;
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b1;
            w_state         <= W_RESP;
          end else begin
            if (s00_axi_awready && s00_axi_awvalid) begin
              aw_held  <= 1'b1;
              awaddr_q <= s00_axi_awaddr[4:2];
            end
            if (s00_axi_wready && s00_axi_wvalid) begin
              w_held  <= 1'b1;
              wdata_q <= s00_axi_wdata;
              wstrb_q <= s00_axi_wstrb;
            end
            s00_axi_awready <= !(aw_held || (s00_axi_awready && s00_axi_awvalid));
            s00_axi_wready  <= !(w_held || (s00_axi_wready && s00_axi_wvalid));
          end
        end
        W_RESP: begin
          if (s00_axi_bready) begin
            s00_axi_bvalid  <= 1'b0;
            s00_axi_awready <= 1'b1;
            s00_axi_wready  <= 1'b1;
            w_state         <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_word = '0;
    case (s00_axi_araddr[4:2])
      3'd0, 3'd1, 3'd2, 3'd3: rd_word = cfg_q[s00_axi_araddr[3:2]];
      3'd4:    rd_word = {{(DW-2){1'b0}}, ctrl_q};
      3'd5:    rd_word = frame_cnt_q;
      3'd6:    rd_word = {{(DW-1){1'b0}}, irq_stat_q};
      3'd7:    rd_word = {{(DW-1){1'b0}}, irq_en_q};
      default: rd_word = '0;
    endcase
  end

  // Read channel: data registered on the AR handshake and held until rready
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state         <= R_IDLE;
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s00_axi_arready && s00_axi_arvalid) begin
            s00_axi_rdata   <= rd_word;
            s00_axi_rvalid  <= 1'b1;
            s00_axi_arready <= 1'b0;
            r_state         <= R_DATA;
          end else begin
            s00_axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s00_axi_rready) begin
            s00_axi_rvalid  <= 1'b0;
            s00_axi_arready <= 1'b1;
            r_state         <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Register file; later assignments win, so a CTRL write beats the commit_once
  // self-clear and a frame-start set beats a same-cycle W1C
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      cfg_q       <= {{(3*DW){1'b0}}, CFG0_RESET};
      cfg_act     <= {{(3*DW){1'b0}}, CFG0_RESET};
      ctrl_q      <= 2'b00;
      frame_cnt_q <= '0;
      irq_stat_q  <= 1'b0;
      irq_en_q    <= 1'b0;
      vsync_p1    <= 1'b0;
      irq         <= 1'b0;
    end else begin
      vsync_p1 <= in_vsync;
      irq      <= irq_stat_q & irq_en_q;
      if (frame_start) begin
        frame_cnt_q <= frame_cnt_q + 32'd1;
        if (ctrl_q[0] || ctrl_q[1]) cfg_act <= cfg_q;
        ctrl_q[1] <= 1'b0;
      end
      if (write_fire) begin
        case (awaddr_q)
          3'd0, 3'd1, 3'd2, 3'd3:
            cfg_q[awaddr_q[1:0]] <= apply_strb(cfg_q[awaddr_q[1:0]], wdata_q, wstrb_q);
          3'd4: if (wstrb_q[0]) ctrl_q <= wdata_q[1:0];
          3'd6: if (wstrb_q[0] && wdata_q[0]) irq_stat_q <= 1'b0;
          3'd7: if (wstrb_q[0]) irq_en_q <= wdata_q[0];
          default: ;
        endcase
      end
      if (frame_start) irq_stat_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_isp_lite_axil_regs.sv
// Directed bench for isp_lite_axil_regs: table-driven register accesses plus
// hand-written sequences for commit, interrupt, back-pressure and reset corners.
module tb_isp_lite_axil_regs;

  localparam logic [31:0] CFG0_RST = 32'hC0FF_EE00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [4:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic        in_vsync = 1'b0;
  logic [31:0] cfg0_active, cfg1_active, cfg2_active, cfg3_active;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  int bcount   = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[11];

  isp_lite_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .CFG0_RESET(CFG0_RST)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .in_vsync(in_vsync),
    .cfg0_active(cfg0_active), .cfg1_active(cfg1_active),
    .cfg2_active(cfg2_active), .cfg3_active(cfg3_active), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bvalid && bready) bcount <= bcount + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // All tasks are entered and left on a falling clock edge.
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly);
    int b0;
    b0 = bcount;
    fork
      begin
        repeat (aw_dly) @(negedge clk);
        awaddr = a; awvalid = 1'b1;
        for (int i = 0; i < 50 && !awready; i++) @(negedge clk);
        chk("awready", awready, 1);
        @(negedge clk); awvalid = 1'b0;
      end
      begin
        repeat (w_dly) @(negedge clk);
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int j = 0; j < 50 && !wready; j++) @(negedge clk);
        chk("wready", wready, 1);
        @(negedge clk); wvalid = 1'b0;
      end
    join
    for (int k = 0; k < 50 && !bvalid; k++) @(negedge clk);
    chk("bvalid", bvalid, 1);
    chk("bresp", bresp, 0);
    @(negedge clk);
    chk("one_bresp_per_write", bcount - b0, 1);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 50 && !arready; i++) @(negedge clk);
    chk("arready", arready, 1);
    @(negedge clk); arvalid = 1'b0;
    chk("rvalid_latency", rvalid, 1);
    chk("rresp", rresp, 0);
    d = rdata;
    @(negedge clk);
  endtask

  task automatic vsync_pulse();
    in_vsync = 1'b1;
    repeat (3) @(negedge clk);
    in_vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic add_vec(input int i, input logic [4:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] e, input string n);
    vecs[i].addr = a; vecs[i].data = d; vecs[i].strb = s; vecs[i].exp = e; vecs[i].name = n;
  endtask

  initial begin
    logic [31:0] rd;
    int b0;

    add_vec(0,  5'h00, 32'h0000_0001, 4'hF, 32'h0000_0001, "cfg0_rw");
    add_vec(1,  5'h04, 32'h0000_0002, 4'hF, 32'h0000_0002, "cfg1_rw");
    add_vec(2,  5'h08, 32'h0000_0003, 4'hF, 32'h0000_0003, "cfg2_rw");
    add_vec(3,  5'h0C, 32'h0000_0004, 4'hF, 32'h0000_0004, "cfg3_rw");
    add_vec(4,  5'h04, 32'hAABB_CCDD, 4'hF, 32'hAABB_CCDD, "cfg1_full");
    add_vec(5,  5'h04, 32'h1122_3344, 4'h5, 32'hAA22_CC44, "cfg1_strb0101");
    add_vec(6,  5'h10, 32'hFFFF_FFFC, 4'hF, 32'h0000_0000, "ctrl_unused_bits");
    add_vec(7,  5'h1C, 32'hFFFF_FFFE, 4'hF, 32'h0000_0000, "irq_en_unused_bits");
    add_vec(8,  5'h14, 32'h0000_1234, 4'hF, 32'h0000_0000, "frame_cnt_ro");
    add_vec(9,  5'h00, 32'hFFFF_FFFF, 4'h0, 32'h0000_0001, "cfg0_strb0");
    add_vec(10, 5'h0C, 32'hDEAD_BEEF, 4'h8, 32'hDE00_0004, "cfg3_strb1000");

    repeat (3) @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resp", {bresp, rresp}, 0);
    chk("rst_irq", irq, 0);
    chk("rst_cfg0_active", cfg0_active, CFG0_RST);
    chk("rst_cfg1_active", cfg1_active, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    axi_read(5'h00, rd); chk("cfg0_reset_value", rd, CFG0_RST);
    for (int i = 0; i < 11; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0);
      axi_read(vecs[i].addr, rd);
      chk(vecs[i].name, rd, vecs[i].exp);
    end

    // Frame start with commit disabled: active config untouched, irq masked
    vsync_pulse();
    chk("nocommit_cfg0_active", cfg0_active, CFG0_RST);
    chk("nocommit_cfg1_active", cfg1_active, 0);
    chk("nocommit_cfg2_active", cfg2_active, 0);
    chk("nocommit_cfg3_active", cfg3_active, 0);
    chk("irq_masked", irq, 0);
    axi_read(5'h14, rd); chk("frame_cnt_1", rd, 1);

    // Read and write of CFG3 in the same cycle: read sees the old value
    chk("rw_idle_ready", {awready, wready, arready}, 3'b111);
    awaddr = 5'h0C; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; araddr = 5'h0C; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    chk("rw_same_rvalid", rvalid, 1);
    chk("rw_same_old_value", rdata, 32'hDE00_0004);
    repeat (2) @(negedge clk);
    axi_read(5'h0C, rd); chk("rw_same_new_value", rd, 32'h1234_5678);

    // Skewed AW/W arrival, then commit_once over two frames
    axi_write(5'h10, 32'h2, 4'hF, 0, 3);
    axi_write(5'h08, 32'h55, 4'hF, 2, 0);
    axi_read(5'h10, rd); chk("ctrl_commit_once", rd, 2);
    axi_read(5'h08, rd); chk("cfg2_skewed", rd, 32'h55);
    vsync_pulse();
    chk("commit_cfg0_active", cfg0_active, 32'h1);
    chk("commit_cfg1_active", cfg1_active, 32'hAA22_CC44);
    chk("commit_cfg2_active", cfg2_active, 32'h55);
    chk("commit_cfg3_active", cfg3_active, 32'h1234_5678);
    axi_read(5'h10, rd); chk("commit_once_cleared", rd, 0);
    axi_write(5'h08, 32'h66, 4'hF, 0, 0);
    vsync_pulse();
    chk("no_second_commit", cfg2_active, 32'h55);
    axi_read(5'h14, rd); chk("frame_cnt_3", rd, 3);

    // Interrupt enable, W1C and latency from the vsync edge
    axi_write(5'h1C, 32'h1, 4'hF, 0, 0);
    @(negedge clk);
    chk("irq_enabled", irq, 1);
    axi_write(5'h18, 32'h1, 4'hF, 0, 0);
    @(negedge clk);
    chk("irq_w1c_low", irq, 0);
    axi_read(5'h18, rd); chk("irq_stat_cleared", rd, 0);
    in_vsync = 1'b1;
    @(negedge clk); chk("irq_edge_plus1", irq, 0);
    @(negedge clk); chk("irq_edge_plus2", irq, 1);
    in_vsync = 1'b0;
    repeat (2) @(negedge clk);

    // W1C landing in the frame-start cycle: the set wins
    b0 = bcount;
    chk("w1c_idle_ready", {awready, wready}, 2'b11);
    awaddr = 5'h18; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; in_vsync = 1'b1;
    @(negedge clk);
    @(negedge clk); in_vsync = 1'b0;
    repeat (2) @(negedge clk);
    chk("w1c_vs_set_bresp", bcount - b0, 1);
    chk("w1c_vs_set_irq", irq, 1);
    axi_read(5'h18, rd); chk("w1c_vs_set_stat", rd, 1);
    axi_read(5'h14, rd); chk("frame_cnt_5", rd, 5);

    // Back-pressure on both channels, then reset in the middle of it
    bready = 1'b0; rready = 1'b0;
    awaddr = 5'h00; wdata = 32'h77; wstrb = 4'hF; araddr = 5'h04;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("hold_bvalid", bvalid, 1);
      chk("hold_rvalid", rvalid, 1);
      chk("hold_rdata", rdata, 32'hAA22_CC44);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_bvalid", bvalid, 0);
    chk("async_rst_rvalid", rvalid, 0);
    chk("async_rst_rdata", rdata, 0);
    chk("async_rst_ready", {awready, wready, arready}, 0);
    chk("async_rst_irq", irq, 0);
    chk("async_rst_cfg0_active", cfg0_active, CFG0_RST);
    chk("async_rst_cfg2_active", cfg2_active, 0);
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    b0 = bcount;
    repeat (3) @(negedge clk);
    chk("no_aborted_bresp", bcount - b0, 0);
    axi_read(5'h00, rd); chk("post_rst_cfg0", rd, CFG0_RST);
    axi_read(5'h14, rd); chk("post_rst_frame_cnt", rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/isp_lite_axil_regs.md
Name: isp_lite_axil_regs

Overview:
AXI4-Lite slave register bank on the S00_AXI port of the ISP-lite IP. It sits directly downstream of the AXI VIP master in the block-design bench and upstream of the ISP pixel pipeline. It holds software-visible configuration and captures pipeline status. Configuration is double-buffered: shadow registers are committed to the pipeline only at frame start, so settings never change mid-frame.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 word registers.
CFG0_RESET, 32'h0000_0000, reset value of CFG0 and of cfg0_active.

Ports:
s00_axi_aclk  in  1  single clock for the whole block
s00_axi_aresetn  in  1  reset, asynchronous, active-low
s00_axi_awaddr  in  5  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid  in  1  write address valid
s00_axi_awready  out  1  write address ready
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte strobes
s00_axi_wvalid  in  1  write data valid
s00_axi_wready  out  1  write data ready
s00_axi_bresp  out  2  write response
s00_axi_bvalid  out  1  write response valid
s00_axi_bready  in  1  write response ready
s00_axi_araddr  in  5  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid  in  1  read address valid
s00_axi_arready  out  1  read address ready
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  read response
s00_axi_rvalid  out  1  read data valid
s00_axi_rready  in  1  read data ready
in_vsync  in  1  pipeline frame sync, active-high
cfg0_active..cfg3_active  out  32 each  committed configuration sent to the pipeline
irq  out  1  level interrupt

Behaviour:
- Register map (word index = addr[4:2]): 0-3 CFG0-CFG3 RW shadow; 4 CTRL RW, bit0 = commit_en, bit1 = commit_once; 5 FRAME_CNT RO; 6 IRQ_STAT W1C, bit0 = frame_start; 7 IRQ_EN RW, bit0 only. Unused bits read 0.
- Reset: all ready/valid outputs 0; bresp = rresp = 0; rdata = 0; CFG0 and cfg0_active = CFG0_RESET; all other registers and active outputs 0; irq = 0.
- Write channel, state machine W_IDLE / W_RESP:
  - In W_IDLE, awready and wready are both high. AW and W may arrive in the same cycle or in different cycles; each one is latched independently and its ready drops once it is captured.
  - When both address and data are held, the register is updated with byte-lane granularity per wstrb. bvalid rises the next cycle with bresp = OKAY, and the FSM enters W_RESP.
  - W_RESP holds until bvalid && bready, then returns to W_IDLE.
  - Only one write is outstanding at a time. Writes to RO registers, and writes with wstrb = 0, complete with OKAY and change nothing.
- Read channel, state machine R_IDLE / R_DATA:
  - arready is high in R_IDLE. On the arvalid handshake, rdata is registered from the addressed register and rvalid rises the next cycle, with rresp = OKAY.
  - rdata stays stable until rready. Read latency is 1 cycle from the AR handshake.
- Read and write channels operate concurrently. If a read and a write hit the same register in the same cycle, the read returns the old value.
- Frame start is the rising edge of in_vsync, detected with a 1-flop delay. On each frame start:
  - FRAME_CNT increments and wraps from 0xFFFF_FFFF to 0.
  - IRQ_STAT bit0 is set.
  - If commit_en or commit_once is set, cfg*_active <= CFG*. commit_once self-clears in the same cycle.
- Set wins over a same-cycle W1C clear of IRQ_STAT bit0.
- A software write to CTRL in the frame-start cycle takes effect for the next frame only.
- irq = IRQ_STAT[0] & IRQ_EN[0], registered.
- Reset asserted mid-transaction aborts the transaction. All state returns to reset values; no response is issued for the aborted access.

Test Plan:
- Write 1, 2, 3, 4 to 0x00, 0x04, 0x08, 0x0C, then read them back -> reads return 1, 2, 3, 4 with OKAY; cfg*_active stay at 0 because commit is disabled.
- AW valid 3 cycles before W; then W valid 2 cycles before AW -> both writes complete with exactly one bvalid each, and data is stored correctly.
- CFG1 = 0xAABBCCDD, then write 0x11223344 with wstrb = 4'b0101 -> CFG1 reads 0xAA22CC44.
- CTRL = 2 (commit_once), CFG2 = 0x55, then 2 vsync pulses -> cfg2_active = 0x55 after the first edge; CTRL reads 0; FRAME_CNT = 2.
- IRQ_EN = 1, vsync pulse -> irq high 2 cycles after the edge; write 1 to IRQ_STAT -> irq low. A W1C issued in the same cycle as a frame start leaves irq high.
- Hold bready and rready low for 5 cycles -> bvalid, rvalid and rdata stay stable; assert ARESETN low mid-burst -> all valids go to 0 immediately (asynchronous reset).
